// File: rtl/fc_mem_ctrl.sv
// fc_mem_ctrl: FC parameter memory write port and row-walk read sequencer (Rev 1.0).
// Optional FC_CTRL_BOUND_CHECK_EN: abort walks whose row would run past the top of memory.
`default_nettype none

module fc_mem_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int ROW_WORDS = 120,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              run_start,
  input  logic [ADDR_W-1:0] run_base,
  input  logic [CNT_W-1:0]  run_rows,
  input  logic [ADDR_W-1:0] run_stride,
  output logic              run_busy,
  output logic              run_done,
  output logic              run_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic              row_valid,
  output logic [CNT_W-1:0]  row_index,
  input  logic              row_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] C_ROW_EXT = (ADDR_W + 1)'(ROW_WORDS);
  localparam logic [ADDR_W:0] C_LIMIT   = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_data_in_q;
  logic                mem_we_q;
  logic                row_valid_q;
  logic [CNT_W-1:0]    row_index_q;
  logic [CNT_W-1:0]    rows_q;
  logic [ADDR_W-1:0]   stride_q;
  logic                run_done_q;
  logic                run_err_q;

  logic                bound_en;
  logic [ADDR_W-1:0]   addr_d;
  logic                last_row;
  logic                base_oob;
  logic                next_oob;

`ifdef FC_CTRL_BOUND_CHECK_EN
  assign bound_en = 1'b1;
`else
  assign bound_en = 1'b0;
`endif

  // Extra top bit lets the row end reach exactly 2^ADDR_W without overflow.
  function automatic logic row_oob(input logic [ADDR_W-1:0] a);
    return (({1'b0, a} + C_ROW_EXT) > C_LIMIT);
  endfunction

  assign addr_d   = mem_address_q + stride_q;
  assign last_row = (row_index_q == (rows_q - 1'b1));
  assign base_oob = bound_en & row_oob(run_base);
  assign next_oob = bound_en & row_oob(addr_d);

  assign wr_ready = (state_q == S_IDLE) & ~run_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      row_valid_q   <= 1'b0;
      row_index_q   <= '0;
      rows_q        <= '0;
      stride_q      <= '0;
      run_done_q    <= 1'b0;
      run_err_q     <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      run_done_q <= 1'b0;
      run_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_start) begin
            rows_q        <= run_rows;
            stride_q      <= run_stride;
            row_index_q   <= '0;
            mem_address_q <= run_base;
            if ((run_rows == '0) || base_oob) begin
              state_q    <= S_DONE;
              run_done_q <= 1'b1;
              run_err_q  <= base_oob;
            end else begin
              state_q     <= S_READ;
              row_valid_q <= 1'b1;
            end
          end else if (wr_valid) begin
            mem_we_q      <= 1'b1;
            mem_address_q <= wr_addr;
            mem_data_in_q <= wr_data;
          end
        end
        S_READ: begin
          if (row_ready) begin
            if (last_row || next_oob) begin
              state_q     <= S_DONE;
              row_valid_q <= 1'b0;
              run_done_q  <= 1'b1;
              run_err_q   <= ~last_row & next_oob;
            end else begin
              mem_address_q <= addr_d;
              row_index_q   <= row_index_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          row_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign run_busy         = (state_q != S_IDLE);
  assign run_done         = run_done_q;
  assign run_err          = run_err_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = row_valid_q;
  assign row_valid        = row_valid_q;
  assign row_index        = row_index_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_mem_ctrl.sv
// tb_fc_mem_ctrl: directed and randomized row walks checked against an arithmetic address model.
`default_nettype none

module tb_fc_mem_ctrl;

  localparam int AW     = 14;
  localparam int DW     = 16;
  localparam int CW     = 8;
  localparam int RW     = 120;
  localparam int ASPACE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          run_start = 1'b0;
  logic [AW-1:0] run_base = '0;
  logic [CW-1:0] run_rows = '0;
  logic [AW-1:0] run_stride = '0;
  logic          row_ready = 1'b0;

  wire           wr_ready;
  wire           run_busy;
  wire           run_done;
  wire           run_err;
  wire [AW-1:0]  mem_address;
  wire [DW-1:0]  mem_data_in;
  wire           mem_write_enable;
  wire           mem_read_enable;
  wire           row_valid;
  wire [CW-1:0]  row_index;

  int total = 0;
  int bad   = 0;

  fc_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ROW_WORDS(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .run_start(run_start), .run_base(run_base), .run_rows(run_rows), .run_stride(run_stride),
    .run_busy(run_busy), .run_done(run_done), .run_err(run_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .row_valid(row_valid), .row_index(row_index), .row_ready(row_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int row_addr(input int base, input int stride, input int k);
    return (base + k * stride) % ASPACE;
  endfunction

  function automatic bit bound_bad(input int a);
`ifdef FC_CTRL_BOUND_CHECK_EN
    return (a + RW) > ASPACE;
`else
    return 1'b0;
`endif
  endfunction

  // Called in IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic run_walk(input string name, input int base, input int rows, input int stride,
                          input bit rnd, input int stall_row, input int stall_n, input bit with_wr);
    int  n_show;
    bit  exp_err;
    bit  r;
    n_show  = rows;
    exp_err = 1'b0;
    for (int i = 0; i < rows; i++) begin
      if (bound_bad(row_addr(base, stride, i))) begin
        n_show  = i;
        exp_err = 1'b1;
        break;
      end
    end
    run_start  = 1'b1;
    run_base   = AW'(base);
    run_rows   = CW'(rows);
    run_stride = AW'(stride);
    wr_valid   = with_wr;
    wr_addr    = 14'h3FF;
    wr_data    = 16'hDEAD;
    #1;
    chk($sformatf("%s wr_ready_at_start", name), {31'b0, wr_ready}, 0);
    tick();
    run_start = 1'b0;
    wr_valid  = 1'b0;
    if (with_wr) chk($sformatf("%s write_blocked", name), {31'b0, mem_write_enable}, 0);
    for (int k = 0; k < n_show; k++) begin
      for (int s = 0; s < 16; s++) begin
        chk($sformatf("%s row%0d valid", name, k), {31'b0, row_valid}, 1);
        chk($sformatf("%s row%0d rd_en", name, k), {31'b0, mem_read_enable}, 1);
        chk($sformatf("%s row%0d addr", name, k), {18'b0, mem_address}, row_addr(base, stride, k));
        chk($sformatf("%s row%0d index", name, k), {24'b0, row_index}, k);
        chk($sformatf("%s row%0d busy", name, k), {31'b0, run_busy}, 1);
        chk($sformatf("%s row%0d done", name, k), {31'b0, run_done}, 0);
        if (k == stall_row && s < stall_n) r = 1'b0;
        else if (rnd && s < 3)             r = 1'($urandom_range(0, 1));
        else                               r = 1'b1;
        row_ready = r;
        tick();
        if (r) break;
      end
    end
    row_ready = 1'b0;
    chk($sformatf("%s done", name), {31'b0, run_done}, 1);
    chk($sformatf("%s err", name), {31'b0, run_err}, {31'b0, exp_err});
    chk($sformatf("%s done_no_row", name), {31'b0, row_valid}, 0);
    chk($sformatf("%s done_busy", name), {31'b0, run_busy}, 1);
    tick();
    chk($sformatf("%s done_pulse_end", name), {31'b0, run_done}, 0);
    chk($sformatf("%s idle_busy", name), {31'b0, run_busy}, 0);
    chk($sformatf("%s idle_wr_ready", name), {31'b0, wr_ready}, 1);
  endtask

  initial begin
    // Reset held for three edges
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst mem_address", {18'b0, mem_address}, 0);
    chk("rst mem_data_in", {16'b0, mem_data_in}, 0);
    chk("rst we", {31'b0, mem_write_enable}, 0);
    chk("rst re", {31'b0, mem_read_enable}, 0);
    chk("rst row_valid", {31'b0, row_valid}, 0);
    chk("rst row_index", {24'b0, row_index}, 0);
    chk("rst busy", {31'b0, run_busy}, 0);
    chk("rst done", {31'b0, run_done}, 0);
    chk("rst err", {31'b0, run_err}, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst wr_ready", {31'b0, wr_ready}, 1);

    // Back-to-back writes
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(120 + i);
      wr_data  = DW'(16'h0011 * (i + 1));
      #1;
      chk($sformatf("wr%0d ready", i), {31'b0, wr_ready}, 1);
      tick();
      chk($sformatf("wr%0d we", i), {31'b0, mem_write_enable}, 1);
      chk($sformatf("wr%0d addr", i), {18'b0, mem_address}, 120 + i);
      chk($sformatf("wr%0d data", i), {16'b0, mem_data_in}, 32'h11 * (i + 1));
    end
    wr_valid = 1'b0;
    tick();
    chk("wr idle we", {31'b0, mem_write_enable}, 0);
    chk("wr idle addr_hold", {18'b0, mem_address}, 122);

    run_walk("walk", 120, 3, 120, 1'b0, -1, 0, 1'b0);
    run_walk("bp", 120, 3, 120, 1'b0, 1, 2, 1'b0);
    run_walk("rows0", 50, 0, 7, 1'b0, -1, 0, 1'b0);
    run_walk("wrrun", 500, 2, 3, 1'b0, -1, 0, 1'b1);

    // Reset during row 1
    run_start = 1'b1; run_base = 14'd120; run_rows = 8'd3; run_stride = 14'd120;
    row_ready = 1'b1;
    tick();
    run_start = 1'b0;
    chk("mid row0 addr", {18'b0, mem_address}, 120);
    tick();
    chk("mid row1 addr", {18'b0, mem_address}, 240);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    row_ready = 1'b0;
    chk("mid rst row_valid", {31'b0, row_valid}, 0);
    chk("mid rst busy", {31'b0, run_busy}, 0);
    chk("mid rst done", {31'b0, run_done}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid post%0d done", i), {31'b0, run_done}, 0);
      chk($sformatf("mid post%0d busy", i), {31'b0, run_busy}, 0);
    end

    run_walk("bound", 16300, 2, 100, 1'b0, -1, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      run_walk($sformatf("rnd%0d", n), int'($urandom_range(0, ASPACE - 1)),
               int'($urandom_range(1, 6)), int'($urandom_range(0, ASPACE - 1)),
               1'b1, -1, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fc_mem_ctrl.md
# fc_mem_ctrl

Controller and arbiter for the fully-connected layer parameter memory (16-bit words, 14-bit address, 120-word combinational row read). It accepts single-word parameter writes from the loader and, on command, walks a sequence of weight or input rows. Each row address is presented to the memory, and the row is handed to the downstream FC MAC with a valid/ready handshake. It sits between the loader/top-level sequencer and the FC memory.

## Interface
- ADDR_W, 14, memory address width
- DATA_W, 16, word width
- ROW_WORDS, 120, words returned per row read
- CNT_W, 8, row counter width

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- wr_valid  in  1  loader write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- run_start  in  1  start row walk (sampled in IDLE only)
- run_base  in  ADDR_W  address of row 0
- run_rows  in  CNT_W  number of rows
- run_stride  in  ADDR_W  address increment between rows
- run_busy  out  1  high in READ and DONE
- run_done  out  1  one-cycle pulse at end of walk
- run_err  out  1  bound error flag, pulses with run_done (see Configuration)
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_write_enable  out  1  memory write strobe
- mem_read_enable  out  1  high while a row is presented
- row_valid  out  1  memory row output valid for the current row
- row_index  out  CNT_W  index of the presented row
- row_ready  in  1  consumer accepts the row

## Operation
- States: IDLE, READ, DONE.
- Reset: state IDLE. All outputs 0, except wr_ready, which follows its combinational rule.
- wr_ready = (state==IDLE) & ~run_start. A run always beats a same-cycle write, and that write is not accepted.
- Write accepted in cycle t: in cycle t+1, mem_write_enable=1, mem_address=wr_addr and mem_data_in=wr_data (all registered). Memory updates at the end of t+1. One write per cycle is sustained.
- IDLE + run_start: latch base, rows and stride.
  - rows==0: go to DONE with no row presented.
  - Otherwise go to READ with idx=0 and addr=base.
- READ:
  - Outputs: mem_address=addr, mem_read_enable=1, row_valid=1, row_index=idx.
  - On row_ready with idx==rows-1: go to DONE.
  - On row_ready otherwise: addr += stride (mod 2^ADDR_W, adder only, no multiplier) and idx++.
  - Without row_ready, hold all outputs.
- DONE: run_done=1 for one cycle, then IDLE. mem_read_enable and row_valid are 0.
- run_start is ignored outside IDLE. wr_valid is stalled (wr_ready=0) outside IDLE.
- mem_address holds its last value in IDLE when no write is issued.
- Reset mid-run: the next edge forces IDLE. row_valid drops, and no run_done is generated.

## Timing
- A write accepted at edge t is visible in memory from cycle t+2. A run started in the cycle after a write (possible because wr_ready is combinational) therefore reads the new data.
- run_start at edge t: row 0 is valid in cycle t+1.
- Row k+1 is valid in the cycle after row k handshakes.
- Walk of N rows with row_ready tied high: READ for N cycles, then run_done in cycle t+N+1, then IDLE.
- rows==0: run_done in cycle t+1.
- Row data is the memory's combinational output. It is valid whenever row_valid=1 and must be captured on the handshake edge.

## Configuration
- FC_CTRL_BOUND_CHECK_EN defined:
  - On each READ entry and each address advance, if addr + ROW_WORDS > 2^ADDR_W, the row is not presented (row_valid=0).
  - The FSM goes to DONE, where run_done=1 and run_err=1 together.
- Not defined: run_err is tied 0, and addresses wrap silently.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> every output 0. wr_ready=1 after release with run_start=0.
- Writes: back-to-back writes to 120/121/122 with data 0x0011/0x0022/0x0033 -> mem_write_enable high for 3 consecutive cycles, each one cycle after acceptance, with matching address and data.
- Walk: base=120, rows=3, stride=120, row_ready=1 -> mem_address 120, 240, 360 and row_index 0, 1, 2 on consecutive cycles. run_done on the 4th cycle after start.
- Backpressure: same walk with row_ready low for 2 cycles on row 1 -> address 240 is held for 3 cycles. Total walk is 2 cycles longer.
- Edge cases:
  - rows=0 -> run_done the cycle after start, with no row_valid.
  - run_start with wr_valid in the same cycle -> write not accepted, walk starts.
  - rst_n low during row 1 -> IDLE, no run_done.
- Bounds: base=16300, rows=2, stride=100.
  - With macro -> run_err=1 with run_done, and no row presented.
  - Without macro -> row 0 at address 16300, row 1 at 16 (wrapped address), run_err=0.
